demux3out3b_reg: RTL and testbench

Registered 1-to-3 demultiplexer for 3-bit fields. It routes one 3-bit value into one of three holding registers selected by a 2-bit code, using a valid/ready handshake. It sits upstream of the 3-input, 3-bit select mux in the datapath and fills the three operand slots (`out1`/`out2`/`out3`) that the mux later chooses between. Each slot holds its value until it is rewritten. Illegal select codes are flagged and never corrupt a slot.

---
 rtl/demux3out3b_reg.sv | 96 +++++++++
 tb/tb_demux3out3b_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/demux3out3b_reg.sv
// Registered 1-to-3 demux for 3-bit operands: a valid/ready transfer is captured,
// then committed into one of three holding slots on the following edge.
module demux3out3b_reg (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] in,
    input  logic [1:0] control,
    input  logic       valid,
    input  logic       clear_err,
    output logic       ready,
    output logic [2:0] out1,
    output logic [2:0] out2,
    output logic [2:0] out3,
    output logic       wr1,
    output logic       wr2,
    output logic       wr3,
    output logic       err,
    output logic [3:0] xfer_count
);

    typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;

    state_t     state_q;
    logic       ready_q;
    logic [2:0] data_q;
    logic [1:0] sel_q;
    logic [2:0] out1_q, out2_q, out3_q;
    logic       wr1_q, wr2_q, wr3_q;
    logic       err_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign cnt_d = cnt_q + 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            ready_q <= 1'b0;
            data_q  <= 3'd0;
            sel_q   <= 2'd0;
            out1_q  <= 3'd0;
            out2_q  <= 3'd0;
            out3_q  <= 3'd0;
            wr1_q   <= 1'b0;
            wr2_q   <= 1'b0;
            wr3_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            wr1_q <= 1'b0;
            wr2_q <= 1'b0;
            wr3_q <= 1'b0;
            // Clear is applied first so an illegal commit on the same edge wins.
            if (clear_err) err_q <= 1'b0;
            case (state_q)
                INIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                IDLE: begin
                    if (valid) begin
                        data_q  <= in;
                        sel_q   <= control;
                        ready_q <= 1'b0;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    case (sel_q)
                        2'd0: begin out1_q <= data_q; wr1_q <= 1'b1; cnt_q <= cnt_d; end
                        2'd1: begin out2_q <= data_q; wr2_q <= 1'b1; cnt_q <= cnt_d; end
                        2'd2: begin out3_q <= data_q; wr3_q <= 1'b1; cnt_q <= cnt_d; end
                        default: err_q <= 1'b1;
                    endcase
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign out1       = out1_q;
    assign out2       = out2_q;
    assign out3       = out3_q;
    assign wr1        = wr1_q;
    assign wr2        = wr2_q;
    assign wr3        = wr3_q;
    assign err        = err_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_demux3out3b_reg.sv
// Directed bench for demux3out3b_reg; inputs change 1 time unit after each rising edge.
module tb_demux3out3b_reg;

    logic       clock = 1'b0;
    logic       reset, valid, clear_err;
    logic [2:0] in;
    logic [1:0] control;
    logic       ready, wr1, wr2, wr3, err;
    logic [2:0] out1, out2, out3;
    logic [3:0] xfer_count;

    int nvec = 0;
    int nmis = 0;

    logic [2:0] m_out [3];
    logic [3:0] m_cnt;

    demux3out3b_reg dut (
        .clock(clock), .reset(reset), .in(in), .control(control),
        .valid(valid), .clear_err(clear_err), .ready(ready),
        .out1(out1), .out2(out2), .out3(out3),
        .wr1(wr1), .wr2(wr2), .wr3(wr3),
        .err(err), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] wrs();
        return {1'b0, wr3, wr2, wr1};
    endfunction

    // One full transfer: accept edge then commit edge; inputs are scrambled after accept.
    task automatic xfer(input logic [2:0] d, input logic [1:0] c);
        logic [3:0] exp_wr;
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        chk("xfer_ready", {3'd0, ready}, 4'd1);
        valid = 1'b1; in = d; control = c;
        step();
        valid = 1'b1; in = ~d; control = c ^ 2'd1;
        chk("xfer_busy", {3'd0, ready}, 4'd0);
        chk("xfer_nowr", wrs(), 4'd0);
        step();
        valid = 1'b0;
        if (c != 2'd3) begin
            m_out[c] = d;
            m_cnt = m_cnt + 4'd1;
            exp_wr = 4'd1 << c;
        end else begin
            exp_wr = 4'd0;
        end
        chk("xfer_wr", wrs(), exp_wr);
        chk("xfer_out1", {1'b0, out1}, {1'b0, m_out[0]});
        chk("xfer_out2", {1'b0, out2}, {1'b0, m_out[1]});
        chk("xfer_out3", {1'b0, out3}, {1'b0, m_out[2]});
        chk("xfer_cnt", xfer_count, m_cnt);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; clear_err = 1'b0; in = 3'd0; control = 2'd0;
        m_out[0] = 3'd0; m_out[1] = 3'd0; m_out[2] = 3'd0; m_cnt = 4'd0;

        // reset
        step(); step();
        chk("rst_ready", {3'd0, ready}, 4'd0);
        chk("rst_out1", {1'b0, out1}, 4'd0);
        chk("rst_out2", {1'b0, out2}, 4'd0);
        chk("rst_out3", {1'b0, out3}, 4'd0);
        chk("rst_wr", wrs(), 4'd0);
        chk("rst_err", {3'd0, err}, 4'd0);
        chk("rst_cnt", xfer_count, 4'd0);
        reset = 1'b0;
        chk("init_ready", {3'd0, ready}, 4'd0);
        step();
        chk("idle_ready", {3'd0, ready}, 4'd1);

        // single writes
        xfer(3'd5, 2'd0);
        step();
        chk("wr1_drop", wrs(), 4'd0);
        xfer(3'd3, 2'd1);
        xfer(3'd6, 2'd2);
        chk("sw_out1", {1'b0, out1}, 4'd5);
        chk("sw_out2", {1'b0, out2}, 4'd3);
        chk("sw_out3", {1'b0, out3}, 4'd6);
        chk("sw_cnt", xfer_count, 4'd3);
        step();
        chk("wr3_drop", wrs(), 4'd0);

        // illegal select
        xfer(3'd7, 2'd3);
        chk("ill_err", {3'd0, err}, 4'd1);
        chk("ill_cnt", xfer_count, 4'd3);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clr_err", {3'd0, err}, 4'd0);
        valid = 1'b1; in = 3'd7; control = 2'd3;
        step();
        valid = 1'b0; clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("set_wins", {3'd0, err}, 4'd1);
        chk("ill2_wr", wrs(), 4'd0);
        chk("ill2_out1", {1'b0, out1}, 4'd5);

        // valid held high, in changes every cycle
        valid = 1'b1; control = 2'd1; in = 3'd1;
        step();
        chk("vh_busy", {3'd0, ready}, 4'd0);
        in = 3'd2;
        step();
        chk("vh_out2a", {1'b0, out2}, 4'd1);
        chk("vh_wr2a", wrs(), 4'd2);
        chk("vh_ready", {3'd0, ready}, 4'd1);
        in = 3'd3;
        step();
        chk("vh_busy2", {3'd0, ready}, 4'd0);
        chk("vh_nowr", wrs(), 4'd0);
        in = 3'd4;
        step();
        valid = 1'b0;
        chk("vh_out2b", {1'b0, out2}, 4'd3);
        chk("vh_wr2b", wrs(), 4'd2);
        chk("vh_cnt", xfer_count, 4'd5);
        step();
        chk("vh_hold", {1'b0, out2}, 4'd3);

        // reset mid-WRITE
        valid = 1'b1; in = 3'd4; control = 2'd2;
        step();
        valid = 1'b0; reset = 1'b1;
        step();
        chk("rm_out3", {1'b0, out3}, 4'd0);
        chk("rm_wr", wrs(), 4'd0);
        chk("rm_cnt", xfer_count, 4'd0);
        chk("rm_err", {3'd0, err}, 4'd0);
        chk("rm_ready", {3'd0, ready}, 4'd0);
        reset = 1'b0;
        step();
        chk("rm_idle", {3'd0, ready}, 4'd1);
        m_out[0] = 3'd0; m_out[1] = 3'd0; m_out[2] = 3'd0; m_cnt = 4'd0;

        // counter wrap over 17 legal writes
        for (int i = 0; i < 17; i++) begin
            xfer(3'(i % 8), 2'(i % 3));
            if (i == 15) chk("wrap_zero", xfer_count, 4'd0);
        end
        chk("wrap_end", xfer_count, 4'd1);
        chk("wrap_out1", {1'b0, out1}, 4'd7);
        chk("wrap_out2", {1'b0, out2}, 4'd0);
        chk("wrap_out3", {1'b0, out3}, 4'd6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
